pipeline_hazard_ctrl: RTL and testbench

//  Sequences the IF/ID and ID/EX pipeline registers. Generates hold, bubble and flush controls for

---
 rtl/pipeline_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hold/bubble/flush sequencing for the IF/ID and ID/EX pipeline registers.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles and flush_events counters.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_WAIT     = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_src1,
    input  logic [4:0]  id_src2,
    input  logic        id_uses_src2,
    input  logic [4:0]  ex_destReg,
    input  logic        ex_regWrite,
    input  logic        ex_memtoreg,
    input  logic        ex_redirect,
    input  logic        mem_busy,
    output logic        pc_hold,
    output logic        if_id_hold,
    output logic        id_ex_hold,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic        wait_timeout,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events,
`endif
    output logic [1:0]  ctrl_state
);

    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_LIMIT   = 8'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       pending_q, pending_d;
    logic       timeout_q, timeout_d;
    logic       load_use, apply_redirect;
    logic       pc_hold_c, if_id_hold_c, id_ex_hold_c, bubble_c, flush_c;

    assign load_use = ex_regWrite && ex_memtoreg && (ex_destReg != 5'd0) &&
                      ((ex_destReg == id_src1) || (id_uses_src2 && (ex_destReg == id_src2)));

    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        pending_d      = pending_q;
        timeout_d      = timeout_q;
        pc_hold_c      = 1'b0;
        if_id_hold_c   = 1'b0;
        id_ex_hold_c   = 1'b0;
        bubble_c       = 1'b0;
        flush_c        = 1'b0;
        apply_redirect = 1'b0;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (mem_busy) begin
                    pc_hold_c    = 1'b1;
                    if_id_hold_c = 1'b1;
                    id_ex_hold_c = 1'b1;
                    state_d      = MEM_WAIT;
                    if (ex_redirect) pending_d = 1'b1;
                    if (wait_cnt_q != 8'hff) wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d >= WAIT_LIMIT) timeout_d = 1'b1;
                end else begin
                    // Leaving a wait behaves exactly like a RUN cycle, plus any parked redirect.
                    wait_cnt_d = 8'd0;
                    pending_d  = 1'b0;
                    state_d    = RUN;
                    if (ex_redirect || pending_q) begin
                        flush_c        = 1'b1;
                        bubble_c       = 1'b1;
                        apply_redirect = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d     = FLUSH;
                            flush_cnt_d = FLUSH_RELOAD;
                        end
                    end else if (load_use) begin
                        pc_hold_c    = 1'b1;
                        if_id_hold_c = 1'b1;
                        bubble_c     = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (mem_busy) begin
                    pc_hold_c    = 1'b1;
                    if_id_hold_c = 1'b1;
                    id_ex_hold_c = 1'b1;
                end else begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (ex_redirect) begin
                        apply_redirect = 1'b1;
                        flush_cnt_d    = FLUSH_RELOAD;
                    end else if (flush_cnt_q <= 3'd1) begin
                        state_d     = RUN;
                        flush_cnt_d = 3'd0;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            flush_cnt_q <= 3'd0;
            wait_cnt_q  <= 8'd0;
            pending_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            pending_q   <= pending_d;
            timeout_q   <= timeout_d;
        end
    end

    // Combinational controls are forced low while reset is asserted.
    assign pc_hold      = rst_n & pc_hold_c;
    assign if_id_hold   = rst_n & if_id_hold_c;
    assign id_ex_hold   = rst_n & id_ex_hold_c;
    assign id_ex_bubble = rst_n & bubble_c;
    assign if_id_flush  = rst_n & flush_c;
    assign wait_timeout = timeout_q;
    assign ctrl_state   = state_q;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if (pc_hold_c) stall_cycles <= stall_cycles + 32'd1;
            if (apply_redirect) flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl against a cycle-level behavioural model.
// Build with HAZARD_PERF_CNT_EN defined to also check the performance counters.
module tb_pipeline_hazard_ctrl;

    localparam int FC = 2;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_src1 = '0, id_src2 = '0, ex_destReg = '0;
    logic        id_uses_src2 = 1'b0, ex_regWrite = 1'b0, ex_memtoreg = 1'b0;
    logic        ex_redirect = 1'b0, mem_busy = 1'b0;
    logic        pc_hold, if_id_hold, id_ex_hold, id_ex_bubble, if_id_flush, wait_timeout;
    logic [1:0]  ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    int n_checks = 0;
    int n_fail = 0;

    // Model: "stalled" memory wait, remaining extra flush cycles, parked redirect, counters.
    bit m_stalled, m_pending, m_timeout;
    int m_flush_left, m_wait_cnt, m_stalls, m_flushes;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_src1(id_src1), .id_src2(id_src2), .id_uses_src2(id_uses_src2),
        .ex_destReg(ex_destReg), .ex_regWrite(ex_regWrite), .ex_memtoreg(ex_memtoreg),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_hold(id_ex_hold),
        .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush), .wait_timeout(wait_timeout),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
        .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stalled = 0; m_pending = 0; m_timeout = 0;
        m_flush_left = 0; m_wait_cnt = 0; m_stalls = 0; m_flushes = 0;
    endtask

    // Compare current outputs with the model's view of this cycle, then advance the model.
    task automatic check_and_advance();
        bit hp, hi, he, bub, fl, lu, r;
        int st;
        hp = 0; hi = 0; he = 0; bub = 0; fl = 0;
        lu = ex_regWrite && ex_memtoreg && ex_destReg != 0 &&
             (ex_destReg == id_src1 || (id_uses_src2 && ex_destReg == id_src2));
        check_eq("timeout", {31'd0, wait_timeout}, {31'd0, m_timeout});
`ifdef HAZARD_PERF_CNT_EN
        check_eq("stall_cycles", stall_cycles, m_stalls);
        check_eq("flush_events", flush_events, m_flushes);
`endif
        if (m_flush_left > 0) begin
            st = 2;
            if (mem_busy) begin
                hp = 1; hi = 1; he = 1;
            end else begin
                fl = 1; bub = 1;
                if (ex_redirect) begin
                    m_flush_left = FC - 1; m_flushes++;
                end else begin
                    m_flush_left--;
                end
            end
        end else begin
            st = m_stalled ? 1 : 0;
            if (mem_busy) begin
                hp = 1; hi = 1; he = 1;
                m_stalled = 1;
                if (ex_redirect) m_pending = 1;
                if (m_wait_cnt < 255) m_wait_cnt++;
                if (m_wait_cnt >= MW) m_timeout = 1;
            end else begin
                r = ex_redirect || m_pending;
                m_stalled = 0; m_pending = 0; m_wait_cnt = 0;
                if (r) begin
                    fl = 1; bub = 1; m_flushes++;
                    m_flush_left = FC - 1;
                end else if (lu) begin
                    hp = 1; hi = 1; bub = 1;
                end
            end
        end
        if (hp) m_stalls++;
        check_eq("ctrl_state", {30'd0, ctrl_state}, st);
        check_eq("controls", {27'd0, pc_hold, if_id_hold, id_ex_hold, id_ex_bubble, if_id_flush},
                 {27'd0, hp, hi, he, bub, fl});
    endtask

    task automatic cycle(input logic busy, input logic redir, input logic [4:0] s1,
                         input logic [4:0] s2, input logic u2, input logic [4:0] dst,
                         input logic rw, input logic mr);
        @(negedge clk);
        mem_busy = busy; ex_redirect = redir; id_src1 = s1; id_src2 = s2;
        id_uses_src2 = u2; ex_destReg = dst; ex_regWrite = rw; ex_memtoreg = mr;
        #1;
        check_and_advance();
    endtask

    task automatic idle();
        cycle(0, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0);
    endtask

    // Asynchronous reset pulse: outputs must drop without waiting for a clock edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_controls", {27'd0, pc_hold, if_id_hold, id_ex_hold, id_ex_bubble, if_id_flush}, 32'd0);
        check_eq("rst_state", {30'd0, ctrl_state}, 32'd0);
        check_eq("rst_timeout", {31'd0, wait_timeout}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check_eq("rst_stall_cycles", stall_cycles, 32'd0);
        check_eq("rst_flush_events", flush_events, 32'd0);
`endif
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        mem_busy = 1'b1; ex_redirect = 1'b1;
        apply_reset();
        mem_busy = 1'b0; ex_redirect = 1'b0;

        // Load-use on rs, then the same with r0 as destination.
        cycle(0, 0, 5'd5, 5'd7, 0, 5'd5, 1, 1);
        check_eq("lu_pc_hold", {31'd0, pc_hold}, 32'd1);
        check_eq("lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
        idle();
        cycle(0, 0, 5'd0, 5'd7, 0, 5'd0, 1, 1);
        check_eq("r0_no_hold", {31'd0, pc_hold}, 32'd0);
        cycle(0, 0, 5'd3, 5'd9, 1, 5'd9, 1, 1);
        check_eq("lu_src2", {31'd0, if_id_hold}, 32'd1);

        // Redirect pulse with FLUSH_CYCLES=2: flush in two cycles, state 0,2,0.
        cycle(0, 1, 5'd5, 5'd5, 1, 5'd5, 1, 1);
        check_eq("redir_flush0", {31'd0, if_id_flush}, 32'd1);
        idle();
        check_eq("redir_state2", {30'd0, ctrl_state}, 32'd2);
        idle();
        check_eq("redir_state0", {30'd0, ctrl_state}, 32'd0);

        // mem_busy 3 cycles with redirect in the second; flush on the 4th.
        cycle(1, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0);
        cycle(1, 1, 5'd1, 5'd2, 0, 5'd0, 0, 0);
        cycle(1, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0);
        check_eq("wait_hold3", {31'd0, id_ex_hold}, 32'd1);
        idle();
        check_eq("wait_flush4", {31'd0, if_id_flush}, 32'd1);
        check_eq("wait_nohold4", {31'd0, pc_hold}, 32'd0);
        idle();
        idle();
`ifdef HAZARD_PERF_CNT_EN
        apply_reset();
        cycle(0, 0, 5'd5, 5'd7, 0, 5'd5, 1, 1);
        idle();
        cycle(1, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0);
        cycle(1, 1, 5'd1, 5'd2, 0, 5'd0, 0, 0);
        cycle(1, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0);
        idle();
        idle();
        idle();
        check_eq("perf_stalls4", stall_cycles, 32'd4);
        check_eq("perf_flush1", flush_events, 32'd1);
        cycle(1, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0);
        cycle(1, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0);
        apply_reset();
`endif

        // Timeout with MAX_WAIT=4: first visible on the 5th busy cycle, sticky afterwards.
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0);
            if (i == 3) check_eq("timeout_c4", {31'd0, wait_timeout}, 32'd0);
            if (i == 4) check_eq("timeout_c5", {31'd0, wait_timeout}, 32'd1);
        end
        idle();
        idle();
        check_eq("timeout_sticky", {31'd0, wait_timeout}, 32'd1);
        cycle(1, 1, 5'd1, 5'd2, 0, 5'd0, 0, 0);
        apply_reset();

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) apply_reset();
            cycle($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
